// File: rtl/req_arbiter_pkg.sv
// Shared types and defaults for the round-robin request arbiter.
// Optional checks are enabled with REQ_ARBITER_ASSERT_EN.
package arb_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

    localparam int ARB_N_REQ    = 4;
    localparam int ARB_MAX_HOLD = 8;

endpackage

// File: rtl/req_arbiter_rr_pick.sv
// Rotating priority search.
// Returns the first set request at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            jj = IW'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// Two-state round-robin arbiter with bounded hold time.
// Define REQ_ARBITER_ASSERT_EN to compile the protocol assertions.
module req_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = ARB_N_REQ,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     timeout
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e     state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]  id_q, id_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [7:0]     hold_q, hold_d;
    logic           busy_q, busy_d;
    logic           to_q, to_d;

    logic           found;
    logic [IW-1:0]  pick;
    logic [IW-1:0]  ptr_nxt;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick)
    );

    assign ptr_nxt = (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                    id_d    = pick;
                    busy_d  = 1'b1;
                    hold_d  = 8'd1;
                end
            end
            GRANT: begin
                // Owner drop and hold expiry both release to a one-cycle IDLE gap
                if (!req[id_q] || hold_q == 8'(MAX_HOLD)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    hold_d  = 8'd0;
                    ptr_d   = ptr_nxt;
                    to_d    = req[id_q];
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            hold_q  <= 8'd0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = id_q;
    assign busy    = busy_q;
    assign timeout = to_q;

`ifdef REQ_ARBITER_ASSERT_EN
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));
    a_busy: assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> (gnt != '0));
    a_idle_grant: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE && req != '0) |=> (gnt != '0));
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        hold_q <= 8'(MAX_HOLD));
    a_to: assert property (@(posedge clk) disable iff (!rst_n)
        timeout |-> !busy);
    for (genvar i = 0; i < N_REQ; i++) begin : g_rel
        a_release: assert property (@(posedge clk) disable iff (!rst_n)
            (gnt[i] && !req[i]) |=> !gnt[i]);
    end
`endif

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (legal range 2..16).
REQ-002 Parameter MAX_HOLD, default 8, max consecutive grant cycles per ownership (legal range 1..255).
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 Port req  input  N_REQ  level request per requester; bit i is requester i.
REQ-006 Port gnt  output  N_REQ  registered one-hot-or-zero grant.
REQ-007 Port gnt_id  output  $clog2(N_REQ)  index of current owner; valid only while busy=1.
REQ-008 Port busy  output  1  registered; 1 while any gnt bit is set.
REQ-009 Port timeout  output  1  registered one-cycle pulse when an ownership is force-released at MAX_HOLD.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-011 In IDLE with req==0, the FSM SHALL stay in IDLE with gnt=0.
REQ-012 In IDLE with req!=0 at edge k, the FSM SHALL pick the first set req bit scanning from ptr upward modulo N_REQ; gnt, gnt_id, busy SHALL update at edge k, with state=GRANT and hold_cnt=1 (one-cycle latency from sampled req to visible gnt).
REQ-013 In GRANT, if req[owner]=0 at an edge, gnt SHALL clear, state SHALL return to IDLE, and ptr SHALL become (owner+1) mod N_REQ.
REQ-014 In GRANT, if req[owner]=1 and hold_cnt==MAX_HOLD, gnt SHALL clear, state SHALL return to IDLE, ptr SHALL become (owner+1) mod N_REQ, and timeout SHALL be 1 for exactly the following cycle.
REQ-015 In GRANT, if req[owner]=1 and hold_cnt<MAX_HOLD, gnt SHALL hold and hold_cnt SHALL increment; gnt stays high at most MAX_HOLD cycles per ownership.
REQ-016 After every release, gnt SHALL be 0 for exactly one cycle (IDLE) before the next grant, even if other requests are pending.
REQ-017 Requests from non-owners during GRANT SHALL be ignored until the next IDLE arbitration; no preemption.
REQ-018 Requester i SHALL never see gnt[i]=1 in a cycle following a sampled req[i]=0 edge (release within one cycle).
REQ-019 ptr wrap: owner N_REQ-1 SHALL set ptr to 0.
REQ-020 hold_cnt SHALL be 8 bits wide and SHALL never exceed MAX_HOLD.

Reset
REQ-021 rst_n=0 sampled at an edge SHALL force state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0, hold_cnt=0, regardless of state, including mid-ownership.
REQ-022 The first grant after reset release SHALL follow REQ-012 with ptr=0.

Configuration
REQ-023 With macro REQ_ARBITER_ASSERT_EN defined, the module SHALL contain concurrent assertions clocked on posedge clk and disabled while rst_n=0: $onehot0(gnt); busy |-> (gnt!=0); (state==IDLE && req!=0) |=> (gnt!=0); gnt[i] && !req[i] |=> !gnt[i]; hold_cnt<=MAX_HOLD; timeout |-> !busy.
REQ-024 Without REQ_ARBITER_ASSERT_EN, no assertions SHALL be compiled, and port behaviour SHALL be cycle-identical.

Structure
REQ-025 Package arb_pkg SHALL hold the state enum (IDLE, GRANT) and the default constants ARB_N_REQ=4 and ARB_MAX_HOLD=8.
REQ-026 The combinational rotate-and-priority search SHALL be a sub-module rr_pick (inputs req, ptr; outputs found, idx).

Verification
REQ-027 Reset: drive req=4'b1111 with rst_n=0 for 3 cycles -> gnt=0, busy=0, timeout=0 throughout; the first edge after rst_n=1 gives gnt=4'b0001.
REQ-028 Round-robin: hold req=4'b1111 and each owner drops req for one cycle after 2 grant cycles -> grant order 0,1,2,3,0, with a one-cycle gnt=0 gap between each.
REQ-029 Timeout: hold req=4'b0100 constant with MAX_HOLD=8 -> gnt=4'b0100 for exactly 8 cycles, then gnt=0 with timeout=1 for one cycle, then gnt=4'b0100 again.
REQ-030 Wrap and skip: ptr=3 and req=4'b0010 -> gnt=4'b0010; after release, req=4'b1010 -> gnt=4'b1000.
REQ-031 Mid-operation reset: rst_n=0 during cycle 5 of ownership of requester 2 -> all outputs zero at the next edge, and the first grant after release goes to the lowest set req bit from ptr=0.
REQ-032 Random run of 10000 cycles, random req, with REQ_ARBITER_ASSERT_EN defined -> zero assertion failures; scoreboard grant order matches the reference round-robin model.
